// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

    localparam int DEFAULT_N = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle between a controller (master) and the subtractor (slave).
interface serial_subtractor_if
    import sub_pkg::*;
#(
    parameter int N = DEFAULT_N
) ();

    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic         ready;
    logic         done;
    logic [N-1:0] Diff;
    logic         Bout;
    logic         Ovf;

    modport master (
        output start, A, B, Bin,
        input  ready, done, Diff, Bout, Ovf
    );

    modport slave (
        input  start, A, B, Bin,
        output ready, done, Diff, Bout, Ovf
    );

endinterface

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: a - b - bin = d - 2*bout.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial Diff = A - B - Bin, LSB first, one full-subtractor step per clock.
//
//   state | meaning
//   IDLE  | waiting for start, ready=1
//   RUN   | one bit step per edge, N edges total, start ignored
//   DONE  | one-cycle done pulse, ready=1, start accepted back-to-back
module serial_subtractor
    import sub_pkg::*;
#(
    parameter  int N  = DEFAULT_N,
    localparam int CW = $clog2(N + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    state_t         state_q,  state_d;
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic [N-1:0]   a_sh_q,   a_sh_d;
    logic [N-1:0]   b_sh_q,   b_sh_d;
    logic [N-1:0]   d_sh_q,   d_sh_d;
    logic           borrow_q, borrow_d;
    logic           sign_a_q, sign_a_d;
    logic           sign_b_q, sign_b_d;
    logic [N-1:0]   diff_q,   diff_d;
    logic           bout_q,   bout_d;
    logic           ovf_q,    ovf_d;

    logic           cell_d;
    logic           cell_bout;

    full_subtractor_cell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        d_sh_d   = d_sh_q;
        borrow_d = borrow_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sh_d   = bus.A;
                    b_sh_d   = bus.B;
                    borrow_d = bus.Bin;
                    sign_a_d = bus.A[N-1];
                    sign_b_d = bus.B[N-1];
                    cnt_d    = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                a_sh_d   = {1'b0, a_sh_q[N-1:1]};
                b_sh_d   = {1'b0, b_sh_q[N-1:1]};
                d_sh_d   = {cell_d, d_sh_q[N-1:1]};
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CW'(1);
                // Last bit step: publish the result in the same edge so Diff never shows partial bits.
                if (cnt_q == CW'(N - 1)) begin
                    diff_d  = {cell_d, d_sh_q[N-1:1]};
                    bout_d  = cell_bout;
                    ovf_d   = (sign_a_q != sign_b_q) && (cell_d != sign_a_q);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_sh_q   <= '0;
            borrow_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            d_sh_q   <= d_sh_d;
            borrow_q <= borrow_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.ready = (state_q != RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.Diff  = diff_q;
    assign bus.Bout  = bout_q;
    assign bus.Ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (N=16) plus a standalone check of the full-subtractor cell.
module tb_serial_subtractor;
    import sub_pkg::*;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor_if #(.N(N)) bus ();

    serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic ca, cb, cbin, cd, cbout;
    full_subtractor_cell u_cell_tb (
        .a    (ca),
        .b    (cb),
        .bin  (cbin),
        .d    (cd),
        .bout (cbout)
    );

    typedef struct packed {
        logic [N-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference: widen to N+1 bits so the top bit is the borrow.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
        logic [N:0] full;
        exp_t       e;
        full   = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
        e.diff = full[N-1:0];
        e.bout = full[N];
        e.ovf  = (a[N-1] != b[N-1]) && (full[N-1] != a[N-1]);
        return e;
    endfunction

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                          input bit noise, input string tag);
        int   lat;
        bit   ready_ok;
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        @(posedge clk);
        sb.push_back(model(a, b, bin));
        lat      = 0;
        ready_ok = 1'b1;
        while (lat <= 2 * N) begin
            @(negedge clk);
            if (bus.done === 1'b1) break;
            if (bus.ready !== 1'b0) ready_ok = 1'b0;
            lat++;
            if (noise) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.A     = N'($urandom_range(0, 65535));
                bus.B     = N'($urandom_range(0, 65535));
                bus.Bin   = 1'($urandom_range(0, 1));
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;

        n_total++;
        if (bus.done !== 1'b1 || lat != N)
            $display("FAIL %s latency: done=%b after %0d cycles, required done=1 after %0d", tag, bus.done, lat, N);
        else n_pass++;

        n_total++;
        if (!ready_ok || bus.ready !== 1'b1)
            $display("FAIL %s ready: low-during-run ok=%b, ready at done=%b, required 1/1", tag, ready_ok, bus.ready);
        else n_pass++;

        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL %s scoreboard: queue empty at done, required one entry", tag);
            e = '0;
        end else begin
            e = sb.pop_front();
            n_pass++;
        end

        n_total++;
        if (bus.Diff !== e.diff) $display("FAIL %s diff: got %h required %h", tag, bus.Diff, e.diff);
        else n_pass++;
        n_total++;
        if (bus.Bout !== e.bout) $display("FAIL %s bout: got %b required %b", tag, bus.Bout, e.bout);
        else n_pass++;
        n_total++;
        if (bus.Ovf !== e.ovf) $display("FAIL %s ovf: got %b required %b", tag, bus.Ovf, e.ovf);
        else n_pass++;

        @(negedge clk);
        n_total++;
        if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.Diff !== e.diff)
            $display("FAIL %s after_done: done=%b ready=%b diff=%h, required 0/1/%h",
                     tag, bus.done, bus.ready, bus.Diff, e.diff);
        else n_pass++;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (bus.ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", bus.ready); else n_pass++;
        n_total++;
        if (bus.done !== 1'b0) $display("FAIL reset_done: got %b required 0", bus.done); else n_pass++;
        n_total++;
        if (bus.Diff !== '0) $display("FAIL reset_diff: got %h required 0000", bus.Diff); else n_pass++;
        n_total++;
        if (bus.Bout !== 1'b0 || bus.Ovf !== 1'b0)
            $display("FAIL reset_flags: bout=%b ovf=%b required 0/0", bus.Bout, bus.Ovf);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cell();
        logic [1:0] r;
        for (int i = 0; i < 8; i++) begin
            ca   = i[2];
            cb   = i[1];
            cbin = i[0];
            #1;
            r = {1'b0, ca} - {1'b0, cb} - {1'b0, cbin};
            n_total++;
            if ({cbout, cd} !== r)
                $display("FAIL cell a=%b b=%b bin=%b: got bout,d=%b%b required %b", ca, cb, cbin, cbout, cd, r);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        run_op(16'h1234, 16'h0034, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_underflow();
        run_op(16'h0000, 16'h0001, 1'b0, 1'b0, "underflow_0m1");
        run_op(16'h0005, 16'h0005, 1'b1, 1'b0, "underflow_bin");
    endtask

    task automatic test_overflow();
        run_op(16'h8000, 16'h0001, 1'b0, 1'b0, "overflow_neg");
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0, "overflow_pos");
    endtask

    task automatic test_ignore_during_run();
        run_op(16'hA5A5, 16'h1357, 1'b1, 1'b1, "ignore_run");
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] oa[4] = '{16'h1111, 16'h0000, 16'h8000, 16'hFFFF};
        logic [N-1:0] ob[4] = '{16'h0111, 16'h0001, 16'h7FFF, 16'h0001};
        logic         obin[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int   idx, seen, cyc, prev;
        bit   stable_ok;
        exp_t e, last;
        last      = '0;
        stable_ok = 1'b1;
        seen      = 0;
        cyc       = 0;
        prev      = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = oa[0];
        bus.B     = ob[0];
        bus.Bin   = obin[0];
        sb.push_back(model(oa[0], ob[0], obin[0]));
        idx = 1;
        while (seen < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) begin
                if (seen > 0) begin
                    n_total++;
                    if (cyc - prev != N + 1)
                        $display("FAIL b2b_interval %0d: got %0d cycles required %0d", seen, cyc - prev, N + 1);
                    else n_pass++;
                end
                e = sb.size() > 0 ? sb.pop_front() : '0;
                n_total++;
                if ({bus.Diff, bus.Bout, bus.Ovf} !== {e.diff, e.bout, e.ovf})
                    $display("FAIL b2b_result %0d: got %h/%b/%b required %h/%b/%b",
                             seen, bus.Diff, bus.Bout, bus.Ovf, e.diff, e.bout, e.ovf);
                else n_pass++;
                last = e;
                prev = cyc;
                seen++;
                if (idx < 4) begin
                    bus.A   = oa[idx];
                    bus.B   = ob[idx];
                    bus.Bin = obin[idx];
                    sb.push_back(model(oa[idx], ob[idx], obin[idx]));
                    idx++;
                end else begin
                    bus.start = 1'b0;
                end
            end else if (seen > 0 && bus.Diff !== last.diff) begin
                stable_ok = 1'b0;
            end
        end
        bus.start = 1'b0;
        n_total++;
        if (seen != 4) $display("FAIL b2b_count: got %0d done pulses required 4", seen); else n_pass++;
        n_total++;
        if (!stable_ok) $display("FAIL b2b_stable: Diff changed between done pulses, required stable"); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        bit no_done;
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0, "pre_abort");
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'h4321;
        bus.B     = 16'h0F0F;
        bus.Bin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL abort_ctrl: ready=%b done=%b required 1/0", bus.ready, bus.done);
        else n_pass++;
        n_total++;
        if (bus.Diff !== '0 || bus.Bout !== 1'b0 || bus.Ovf !== 1'b0)
            $display("FAIL abort_outputs: diff=%h bout=%b ovf=%b required 0000/0/0", bus.Diff, bus.Bout, bus.Ovf);
        else n_pass++;
        no_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            if (bus.done !== 1'b0) no_done = 1'b0;
        end
        n_total++;
        if (!no_done) $display("FAIL abort_no_done: done pulsed after abort, required none"); else n_pass++;
        n_total++;
        if (bus.ready !== 1'b1) $display("FAIL abort_ready: got %b required 1", bus.ready); else n_pass++;
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "post_abort");
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            run_op(N'($urandom_range(0, 65535)), N'($urandom_range(0, 65535)),
                   1'($urandom_range(0, 1)), (i % 4) == 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_cell();
        test_basic();
        test_underflow();
        test_overflow();
        test_ignore_during_run();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametric, bit-serial computation of Diff = A - B - Bin. It is the inverse operation to the team's parallel N-bit adder.
- It processes one bit per clock, LSB first, using a single full-subtractor cell.
- It trades latency for area in the lab datapath.
- It uses a start/ready/done handshake so a controller FSM can issue operands and collect results.

Parameters:
- N, 16, operand width in bits; legal range N >= 2.
- CW, $clog2(N+1), bit-counter width; derived, not overridden.

Ports:
- clk    in   1    rising-edge clock.
- rst_n  in   1    asynchronous, active-low reset.
- start  in   1    request; accepted only on an edge where ready=1.
- A      in   N    minuend, sampled on acceptance.
- B      in   N    subtrahend, sampled on acceptance.
- Bin    in   1    borrow-in, sampled on acceptance.
- ready  out  1    high in IDLE and DONE; block can accept start.
- done   out  1    one-cycle pulse; result valid.
- Diff   out  N    difference, A - B - Bin mod 2^N.
- Bout   out  1    borrow-out; 1 iff A < B + Bin (unsigned).
- Ovf    out  1    signed overflow of A - B - Bin (two's complement).

Behaviour:
- Reset (rst_n=0, any time, asynchronous):
  - state=IDLE, counter=0, shift registers=0, borrow=0.
  - Outputs: ready=1, done=0, Diff=0, Bout=0, Ovf=0.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - start=1 at an edge: load a_sh<=A, b_sh<=B, borrow<=Bin, sign_a<=A[N-1], sign_b<=B[N-1], cnt<=0; go to RUN.
- RUN:
  - ready=0; start is ignored.
  - Each edge performs one bit step:
    - d = a_sh[0]^b_sh[0]^borrow.
    - borrow <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow).
    - a_sh, b_sh shift right by 1.
    - d shifts into the MSB of d_sh.
    - cnt <= cnt+1.
  - On the edge where cnt==N-1 (the Nth bit step), go to DONE and also register the outputs:
    - Diff <= completed d_sh.
    - Bout <= final borrow.
    - Ovf <= (sign_a != sign_b) && (Diff MSB != sign_a).
- DONE:
  - done=1 and ready=1 for exactly one cycle.
  - Next edge: start=1 behaves as an IDLE acceptance (back-to-back, no idle gap); start=0 goes to IDLE.
- Latency: accept at edge k; done high during the cycle after edge k+N. Throughput is one result per N+1 cycles.
- Diff/Bout/Ovf change only at the completing edge. They hold their value through IDLE and through the next RUN until that run completes.
- The internal shift register is never visible on Diff.
- start held high continuously: a new operation is accepted at each opportunity, every N+1 cycles.
- A, B and Bin changing during RUN has no effect.
- Arithmetic is modulo 2^N. Bout and Ovf are independent flags.

Decomposition:
- Shared package sub_pkg holds:
  - the state enum {IDLE, RUN, DONE}, 2-bit encoding 00/01/10;
  - localparam default width 16.
- One sub-module, full_subtractor_cell (a, b, bin -> d, bout), combinational. It is instantiated once and also unit-tested on its own.
- FSM, counter and shift registers stay in serial_subtractor.

Test Plan (N=16):
- Basic: A=0x1234, B=0x0034, Bin=0, start pulse -> done 16 edges after acceptance; Diff=0x1200, Bout=0, Ovf=0; ready low throughout RUN.
- Underflow: A=0x0000, B=0x0001, Bin=0 -> Diff=0xFFFF, Bout=1, Ovf=0. Then A=5, B=5, Bin=1 -> Diff=0xFFFF, Bout=1.
- Overflow: A=0x8000, B=0x0001, Bin=0 -> Diff=0x7FFF, Ovf=1, Bout=0. Then A=0x7FFF, B=0xFFFF -> Diff=0x8000, Ovf=1, Bout=1.
- Handshake:
  - Toggle start and change A/B during RUN -> ignored; result matches the first operands.
  - start held high -> done pulses every 17 cycles with no idle cycle.
  - Diff stays stable between done pulses.
- Reset mid-run: assert rst_n=0 at bit 7, asynchronously between edges -> outputs clear immediately, no done pulse. After release: ready=1, and a new op A=0xFFFF, B=0xFFFF gives Diff=0x0000, Bout=0.
- Random: 1000 random A/B/Bin -> Diff, Bout and Ovf match the reference model {Bout,Diff} = A - B - Bin (Bout = borrow), with done latency always N.
